// File: rtl/muldiv_unit.sv
// muldiv_unit: MULT/MULTU/DIV/DIVU into HI/LO, 33-cycle iterative latency (MULT/MULTU 1 cycle with MULDIV_FAST_MUL_EN).
// No backpressure: start is ignored while busy, and the caller stalls on busy until the done pulse.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand magnitudes; op[0]=1 selects the unsigned variants.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_abs = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_abs = b_neg ? (~b + WIDTH'(1)) : b;

  // Shift-add step: low half holds remaining multiplier bits, high half the partial product.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_addend = acc_q[0] ? b_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: high half is the remainder, low half shifts dividend out / quotient in.
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, b_q};
  assign div_diff = rem_sh[WIDTH-1:0] - b_q;
  assign rem_new  = div_ge ? div_diff : rem_sh[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_mag;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_q};
  assign prod_mag  = op_q[1] ? acc_q : fast_prod;
`else
  assign prod_mag  = acc_q;
`endif

  // Sign fix-up; a zero divisor leaves the remainder equal to a and forces an all-ones quotient.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
  assign quo_fix  = div0_q ? {WIDTH{1'b1}} :
                    (neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          acc_d     = {{WIDTH{1'b0}}, a_abs};
          b_d       = b_abs;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (b == {WIDTH{1'b0}});
          cnt_d     = '0;
          state_d   = CALC;
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) state_d = FIX;
`endif
        end else begin
          if (wr_hi) hi_d = wd;
          if (wr_lo) lo_d = wd;
        end
      end
      CALC: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency, MTHI/MTLO and reset abort.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             wr_hi = 1'b0;
  logic             wr_lo = 1'b0;
  logic [WIDTH-1:0] wd = '0;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present an op at the negedge so it is sampled at edge T0; operands are scrambled afterwards.
  task automatic launch(input logic [1:0] o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'h5A5A_A5A5; b = 32'h0F0F_F0F0; op = ~o;
    cyc = 0;
  endtask

  task automatic finish_op(input string tag, input int lat,
                           input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo);
    while (!done && cyc < 100) tick();
    chk({tag, "_lat"},  cyc,  lat);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_hi"},   hi,   ehi);
    chk({tag, "_lo"},   lo,   elo);
    tick();
    chk({tag, "_done_drop"}, done, 1'b0);
  endtask

  int ndone;
  int first_done;
  logic [WIDTH-1:0] cap_hi, cap_lo;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi",   hi,   32'h0);
    chk("rst_lo",   lo,   32'h0);
    rst_n = 1'b1;

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_busy", busy, 1'b1);
    finish_op("multu_max", MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);

    launch(2'b00, 32'hFFFF_FFF9, 32'd3);
    finish_op("mult_neg", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg", DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(2'b11, 32'd100, 32'd7);
    finish_op("divu_100_7", DIV_LAT, 32'd2, 32'd14);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", DIV_LAT, 32'h0, 32'h8000_0000);

    // Divide by zero with a second start pulsed mid-operation.
    launch(2'b11, 32'd1234, 32'd0);
    ndone = 0; first_done = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_done = i; cap_hi = hi; cap_lo = lo; end
      end
      if (i == 5) begin start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; end
      else if (i == 6) start = 1'b0;
    end
    chk("div0_ndone", ndone, 1);
    chk("div0_lat",   first_done, DIV_LAT);
    chk("div0_hi",    cap_hi, 32'd1234);
    chk("div0_lo",    cap_lo, 32'hFFFF_FFFF);

    // MTHI/MTLO while idle.
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h0000_1234;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mt_both_hi", hi, 32'h0000_1234);
    chk("mt_both_lo", lo, 32'h0000_1234);
    wr_hi = 1'b1; wd = 32'hAAAA_5555;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wd = 32'h0000_0001;
    chk("mthi_hi", hi, 32'hAAAA_5555);
    chk("mthi_lo", lo, 32'h0000_1234);
    @(negedge clk); wr_lo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_0001);
    chk("mtlo_hi", hi, 32'hAAAA_5555);

    // wr_lo while busy is ignored; hi/lo hold through CALC.
    launch(2'b11, 32'd100, 32'd7);
    wr_lo = 1'b1; wd = 32'hDEAD_BEEF;
    repeat (3) tick();
    wr_lo = 1'b0;
    tick();
    chk("busy_wrlo_lo", lo, 32'h0000_0001);
    chk("busy_hold_hi", hi, 32'hAAAA_5555);
    finish_op("busy_wrlo", DIV_LAT, 32'd2, 32'd14);

    // start and wr_hi in the same cycle: start wins, HI is not written.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7; wr_hi = 1'b1; wd = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    start = 1'b0; wr_hi = 1'b0; cyc = 0;
    chk("prio_busy", busy, 1'b1);
    chk("prio_hi",   hi,   32'd2);
    finish_op("prio", DIV_LAT, 32'd2, 32'd14);

    // Asynchronous reset mid-CALC aborts with no later done.
    launch(2'b11, 32'd100, 32'd7);
    repeat (10) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_hi",   hi,   32'h0);
    chk("arst_lo",   lo,   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    chk("arst_idle",    busy,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
